// File: rtl/hsid_pkg.sv
// Shared types and default widths for the HSID pixel-identification controller.
package hsid_pkg;

    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 8;
    localparam int HSID_MSE_TIMEOUT       = 64;

    typedef enum logic [3:0] {
        IDLE              = 4'd0,
        CONFIG            = 4'd1,
        READ_HSP_CAPTURED = 4'd2,
        COMPUTE_MSE       = 4'd3,
        WAIT_MSE          = 4'd4,
        COMPARE_MSE       = 4'd5,
        DONE              = 4'd6,
        ERROR             = 4'd7,
        CLEAR             = 4'd8
    } hsid_main_ctrl_state_t;

endpackage

// File: rtl/hsid_band_pack_seq.sv
// Band-pack issue/delivery sequencer: pops both FIFOs until every pack of every
// reference has been issued and qualifies each delivered pack with start/last.
module hsid_band_pack_seq #(
    parameter int HSP_BANDS_WIDTH   = 8,
    parameter int HSP_LIBRARY_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         initialize,
    input  logic                         fifo_captured_empty,
    input  logic                         fifo_ref_empty,
    input  logic [HSP_BANDS_WIDTH-1:0]   threshold,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    output logic                         read_en,
    output logic                         band_pack_valid,
    output logic                         band_pack_start,
    output logic                         band_pack_last,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count,
    output logic                         last_ref
);

    localparam int IW = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH;

    logic [IW-1:0]              issued_r;
    logic [IW-1:0]              total_s;
    logic [HSP_BANDS_WIDTH-1:0] pack_cnt_r;
    logic [HSP_BANDS_WIDTH-1:0] pack_cnt_next_s;

    assign total_s  = IW'(threshold) * IW'(library_size);
    assign read_en  = enable && !fifo_captured_empty && !fifo_ref_empty && (issued_r < total_s);
    assign last_ref = band_pack_last && (hsp_ref_count == library_size - 1'b1);

    // Pack index within the current reference as it will be after this cycle's delivery.
    always_comb begin
        pack_cnt_next_s = pack_cnt_r;
        if (band_pack_valid && band_pack_last) begin
            pack_cnt_next_s = '0;
        end else if (band_pack_valid) begin
            pack_cnt_next_s = pack_cnt_r + 1'b1;
        end else begin
            pack_cnt_next_s = pack_cnt_r;
        end
    end

    // Issue counter, pack index, reference index and the registered pack qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_r        <= '0;
            pack_cnt_r      <= '0;
            band_pack_valid <= 1'b0;
            band_pack_start <= 1'b0;
            band_pack_last  <= 1'b0;
            hsp_ref_count   <= '0;
        end else if (initialize) begin
            issued_r        <= '0;
            pack_cnt_r      <= '0;
            band_pack_valid <= 1'b0;
            band_pack_start <= 1'b0;
            band_pack_last  <= 1'b0;
            hsp_ref_count   <= '0;
        end else begin
            if (read_en) begin
                issued_r <= issued_r + 1'b1;
            end
            pack_cnt_r      <= pack_cnt_next_s;
            band_pack_valid <= read_en;
            // start/last are predicted from the post-delivery index so they stay registered
            band_pack_start <= read_en && (pack_cnt_next_s == '0);
            band_pack_last  <= read_en && (pack_cnt_next_s == threshold - 1'b1);
            if (band_pack_last) begin
                hsp_ref_count <= hsp_ref_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hsid_main_ctrl.sv
// HSID main controller: sequences configuration, captured-pixel load, band-pack
// streaming of all references and the final MSE compare, with watchdog and clear.
module hsid_main_ctrl
    import hsid_pkg::*;
#(
    parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter int BANDS_PER_PACK    = 2,
    parameter int MSE_TIMEOUT       = HSID_MSE_TIMEOUT,
    parameter int PIXEL_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         stop,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    input  logic                         fifo_captured_complete,
    input  logic                         fifo_captured_empty,
    input  logic                         fifo_ref_empty,
    input  logic                         fifo_ref_full,
    input  logic                         mse_valid,
    input  logic                         mse_comparison_valid,
    output logic                         fifo_both_read_en,
    output logic                         band_pack_valid,
    output logic                         band_pack_start,
    output logic                         band_pack_last,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count,
    output logic [PIXEL_COUNT_WIDTH-1:0] pixel_count,
    output logic                         initialize,
    output logic                         idle,
    output logic                         ready,
    output logic                         done,
    output logic                         error,
    output logic                         cancelled
);

    localparam int LOG2_BPP = $clog2(BANDS_PER_PACK);
    localparam int TW       = $clog2(MSE_TIMEOUT + 1);
    localparam int PW       = HSP_LIBRARY_WIDTH + 1;

    hsid_main_ctrl_state_t state_r, state_next_s;

    logic [HSP_BANDS_WIDTH-1:0]   cfg_hsp_bands_r;
    logic [HSP_LIBRARY_WIDTH-1:0] cfg_hsp_library_size_r;
    logic                         cfg_continuous_r;
    logic [HSP_BANDS_WIDTH:0]     thr_sum_s;
    logic [HSP_BANDS_WIDTH-1:0]   cfg_band_pack_threshold_s;
    logic [PW-1:0]                mse_pending_r;
    logic [TW-1:0]                wd_timer_r;
    logic                         in_mse_s;
    logic                         wd_expired_s;
    logic                         last_ref_s;

    // Extra MSB keeps the round-up addition from overflowing at the maximum band count
    assign thr_sum_s = {1'b0, cfg_hsp_bands_r} + (HSP_BANDS_WIDTH + 1)'(BANDS_PER_PACK - 1);
    assign cfg_band_pack_threshold_s = HSP_BANDS_WIDTH'(thr_sum_s >> LOG2_BPP);

    assign idle       = (state_r == IDLE);
    assign ready      = (state_r == READ_HSP_CAPTURED) || (state_r == COMPUTE_MSE);
    assign done       = (state_r == DONE);
    assign error      = (state_r == ERROR);
    assign cancelled  = (state_r == CLEAR);
    assign initialize = (state_r == DONE) || (state_r == ERROR) || (state_r == CLEAR);

    assign in_mse_s     = (state_r == WAIT_MSE) || (state_r == COMPARE_MSE);
    assign wd_expired_s = in_mse_s && (wd_timer_r == TW'(MSE_TIMEOUT - 1));

    hsid_band_pack_seq #(
        .HSP_BANDS_WIDTH   (HSP_BANDS_WIDTH),
        .HSP_LIBRARY_WIDTH (HSP_LIBRARY_WIDTH)
    ) u_seq (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (state_r == COMPUTE_MSE),
        .initialize          (initialize),
        .fifo_captured_empty (fifo_captured_empty),
        .fifo_ref_empty      (fifo_ref_empty),
        .threshold           (cfg_band_pack_threshold_s),
        .library_size        (cfg_hsp_library_size_r),
        .read_en             (fifo_both_read_en),
        .band_pack_valid     (band_pack_valid),
        .band_pack_start     (band_pack_start),
        .band_pack_last      (band_pack_last),
        .hsp_ref_count       (hsp_ref_count),
        .last_ref            (last_ref_s)
    );

    // Next-state logic; clear outranks every other transition in the active states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = CONFIG;
                else       state_next_s = IDLE;
            end
            CONFIG: begin
                if (clear)                                          state_next_s = CLEAR;
                else if ((hsp_bands == '0) || (hsp_library_size == '0)) state_next_s = ERROR;
                else                                                state_next_s = READ_HSP_CAPTURED;
            end
            READ_HSP_CAPTURED: begin
                if (clear)                       state_next_s = CLEAR;
                else if (fifo_captured_complete) state_next_s = COMPUTE_MSE;
                else                             state_next_s = READ_HSP_CAPTURED;
            end
            COMPUTE_MSE: begin
                if (clear)              state_next_s = CLEAR;
                else if (fifo_ref_full) state_next_s = ERROR;
                else if (last_ref_s)    state_next_s = WAIT_MSE;
                else                    state_next_s = COMPUTE_MSE;
            end
            WAIT_MSE: begin
                if (clear)                                       state_next_s = CLEAR;
                else if (mse_valid && (mse_pending_r == PW'(1))) state_next_s = COMPARE_MSE;
                else if (wd_expired_s)                           state_next_s = ERROR;
                else                                             state_next_s = WAIT_MSE;
            end
            COMPARE_MSE: begin
                if (clear)                     state_next_s = CLEAR;
                else if (mse_comparison_valid) state_next_s = DONE;
                else if (wd_expired_s)         state_next_s = ERROR;
                else                           state_next_s = COMPARE_MSE;
            end
            DONE: begin
                if (cfg_continuous_r && !stop && !clear) state_next_s = READ_HSP_CAPTURED;
                else                                     state_next_s = IDLE;
            end
            ERROR:   state_next_s = IDLE;
            CLEAR:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Configuration latch; parked at all ones whenever the block returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_hsp_bands_r        <= '1;
            cfg_hsp_library_size_r <= '1;
            cfg_continuous_r       <= 1'b1;
        end else if (state_r == CONFIG) begin
            cfg_hsp_bands_r        <= hsp_bands;
            cfg_hsp_library_size_r <= hsp_library_size;
            cfg_continuous_r       <= continuous;
        end else if ((state_next_s == IDLE) && (state_r != IDLE)) begin
            cfg_hsp_bands_r        <= '1;
            cfg_hsp_library_size_r <= '1;
            cfg_continuous_r       <= 1'b1;
        end
    end

    // References streamed but not yet compared by the MSE pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mse_pending_r <= '0;
        end else if (initialize) begin
            mse_pending_r <= '0;
        end else begin
            case ({band_pack_last, mse_comparison_valid})
                2'b10: mse_pending_r <= mse_pending_r + 1'b1;
                2'b01: begin
                    if (mse_pending_r != '0) mse_pending_r <= mse_pending_r - 1'b1;
                end
                default: mse_pending_r <= mse_pending_r;
            endcase
        end
    end

    // Watchdog over the combined WAIT_MSE/COMPARE_MSE residency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       wd_timer_r <= '0;
        else if (initialize || !in_mse_s) wd_timer_r <= '0;
        else                              wd_timer_r <= wd_timer_r + 1'b1;
    end

    // Pixels completed since the last accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        pixel_count <= '0;
        else if ((state_r == IDLE) && start) pixel_count <= '0;
        else if (state_r == DONE)          pixel_count <= pixel_count + 1'b1;
    end

endmodule

// File: tb/tb_hsid_main_ctrl.sv
// Self-checking bench for hsid_main_ctrl: vector table, randomized FIFO stalls
// against a pack-count model, and directed clear/watchdog/overflow/reset sequences.
module tb_hsid_main_ctrl;

    localparam int BW  = 8;
    localparam int LW  = 8;
    localparam int PCW = 16;
    localparam int BPP = 4;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst_n, clear, start, continuous, stop;
    logic [BW-1:0] hsp_bands;
    logic [LW-1:0] hsp_library_size;
    logic fifo_captured_complete, fifo_captured_empty, fifo_ref_empty, fifo_ref_full;
    logic mse_valid, mse_comparison_valid;
    logic fifo_both_read_en, band_pack_valid, band_pack_start, band_pack_last;
    logic [LW-1:0]  hsp_ref_count;
    logic [PCW-1:0] pixel_count;
    logic initialize, idle, ready, done, error, cancelled;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_pix = 0;

    typedef struct {
        int bands;
        int lib;
        int thr;
        bit err;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    hsid_main_ctrl #(
        .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW), .BANDS_PER_PACK(BPP),
        .MSE_TIMEOUT(TMO), .PIXEL_COUNT_WIDTH(PCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .continuous(continuous),
        .stop(stop), .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
        .fifo_captured_complete(fifo_captured_complete), .fifo_captured_empty(fifo_captured_empty),
        .fifo_ref_empty(fifo_ref_empty), .fifo_ref_full(fifo_ref_full),
        .mse_valid(mse_valid), .mse_comparison_valid(mse_comparison_valid),
        .fifo_both_read_en(fifo_both_read_en), .band_pack_valid(band_pack_valid),
        .band_pack_start(band_pack_start), .band_pack_last(band_pack_last),
        .hsp_ref_count(hsp_ref_count), .pixel_count(pixel_count), .initialize(initialize),
        .idle(idle), .ready(ready), .done(done), .error(error), .cancelled(cancelled)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full pixel; first=1 starts from IDLE, otherwise from a re-armed READ_HSP_CAPTURED.
    task automatic do_pixel(input int bands, input int lib, input int thr, input bit err,
                            input bit first, input bit cont, input bit stall,
                            input bit stop_it, input bit exp_cont, input bit clr_done);
        int reads, packs, starts, lasts, cyc;
        bit prev_rd;
        reads = 0; packs = 0; starts = 0; lasts = 0; cyc = 0; prev_rd = 1'b0;
        if (first) begin
            hsp_bands = BW'(bands); hsp_library_size = LW'(lib); continuous = cont;
            start = 1'b1;
            step();
            start = 1'b0;
            #1;
            chk("config_not_idle", 32'(idle), 32'd0);
            chk("config_pix_zero", 32'(pixel_count), 32'd0);
            exp_pix = 0;
            step(); #1;
            if (err) begin
                chk("cfg_error", 32'(error), 32'd1);
                chk("cfg_error_init", 32'(initialize), 32'd1);
                step(); #1;
                chk("cfg_error_to_idle", 32'(idle), 32'd1);
                chk("cfg_error_one_cycle", 32'(error), 32'd0);
                return;
            end
            chk("cfg_no_error", 32'(error), 32'd0);
        end
        chk("read_ready", 32'(ready), 32'd1);
        stop = stop_it;
        fifo_captured_complete = 1'b1;
        step();
        fifo_captured_complete = 1'b0;
        while (cyc < 4000) begin
            fifo_captured_empty = stall && ($urandom_range(0, 3) == 0);
            fifo_ref_empty      = stall && ($urandom_range(0, 2) == 0);
            #1;
            if (!ready) break;
            chk("valid_lag", 32'(band_pack_valid), 32'(prev_rd));
            if (band_pack_valid) begin
                chk("pack_start", 32'(band_pack_start), 32'((packs % thr) == 0));
                chk("pack_last", 32'(band_pack_last), 32'((packs % thr) == thr - 1));
                chk("pack_ref_idx", 32'(hsp_ref_count), 32'(packs / thr));
                if (band_pack_start) starts++;
                if (band_pack_last) lasts++;
                packs++;
            end
            chk("read_en", 32'(fifo_both_read_en),
                32'(!fifo_captured_empty && !fifo_ref_empty && (reads < thr * lib)));
            if (fifo_both_read_en) reads++;
            prev_rd = fifo_both_read_en;
            step();
            cyc++;
        end
        fifo_captured_empty = 1'b0;
        fifo_ref_empty = 1'b0;
        chk("compute_budget", 32'(cyc < 4000), 32'd1);
        chk("total_reads", 32'(reads), 32'(thr * lib));
        chk("total_starts", 32'(starts), 32'(lib));
        chk("total_lasts", 32'(lasts), 32'(lib));
        chk("ref_count_final", 32'(hsp_ref_count), 32'(lib));
        // mse_valid is ignored until only one comparison is outstanding
        mse_valid = 1'b1; step(); mse_valid = 1'b0; #1;
        chk("wait_hold", 32'(done), 32'd0);
        for (int i = 0; i < lib - 1; i++) begin
            mse_comparison_valid = 1'b1; step(); mse_comparison_valid = 1'b0; #1;
            chk("wait_drain_no_done", 32'(done), 32'd0);
        end
        mse_valid = 1'b1; step(); mse_valid = 1'b0; #1;
        chk("compare_no_done", 32'(done), 32'd0);
        mse_comparison_valid = 1'b1; step(); mse_comparison_valid = 1'b0;
        clear = clr_done;
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_init", 32'(initialize), 32'd1);
        chk("done_pix_before", 32'(pixel_count), 32'(exp_pix));
        step();
        clear = 1'b0; stop = 1'b0;
        exp_pix++;
        #1;
        chk("pix_after_done", 32'(pixel_count), 32'(exp_pix));
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ref_cleared", 32'(hsp_ref_count), 32'd0);
        if (exp_cont) begin
            chk("rearm_ready", 32'(ready), 32'd1);
            chk("rearm_not_idle", 32'(idle), 32'd0);
        end else begin
            chk("done_to_idle", 32'(idle), 32'd1);
        end
    endtask

    task automatic go_compute(input int bands, input int lib);
        hsp_bands = BW'(bands); hsp_library_size = LW'(lib); continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        fifo_captured_complete = 1'b1; step(); fifo_captured_complete = 1'b0;
    endtask

    task automatic run_to_wait();
        int c;
        c = 0;
        fifo_captured_empty = 1'b0; fifo_ref_empty = 1'b0;
        while (c < 1000) begin
            #1;
            if (!ready) break;
            step();
            c++;
        end
        chk("wait_budget", 32'(c < 1000), 32'd1);
    endtask

    task automatic clear_in(input int stage);
        hsp_bands = 8'd10; hsp_library_size = 8'd2; continuous = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        if (stage >= 1) step();
        if (stage >= 2) begin
            fifo_captured_complete = 1'b1; step(); fifo_captured_complete = 1'b0;
        end
        if (stage == 2) begin step(); step(); end
        if (stage >= 3) run_to_wait();
        if (stage >= 4) begin
            mse_comparison_valid = 1'b1; step(); mse_comparison_valid = 1'b0;
            mse_valid = 1'b1; step(); mse_valid = 1'b0;
        end
        clear = 1'b1; step(); clear = 1'b0; #1;
        chk($sformatf("clr%0d_cancelled", stage), 32'(cancelled), 32'd1);
        chk($sformatf("clr%0d_init", stage), 32'(initialize), 32'd1);
        chk($sformatf("clr%0d_no_done", stage), 32'(done), 32'd0);
        step(); #1;
        chk($sformatf("clr%0d_idle", stage), 32'(idle), 32'd1);
        chk($sformatf("clr%0d_cancel_1cyc", stage), 32'(cancelled), 32'd0);
        chk($sformatf("clr%0d_ref_zero", stage), 32'(hsp_ref_count), 32'd0);
        chk($sformatf("clr%0d_valid_zero", stage), 32'(band_pack_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, b, l;
        vecs[0] = '{bands: 10,  lib: 3, thr: 3,  err: 1'b0};
        vecs[1] = '{bands: 0,   lib: 3, thr: 1,  err: 1'b1};
        vecs[2] = '{bands: 5,   lib: 0, thr: 1,  err: 1'b1};
        vecs[3] = '{bands: 4,   lib: 2, thr: 1,  err: 1'b0};
        vecs[4] = '{bands: 1,   lib: 1, thr: 1,  err: 1'b0};
        vecs[5] = '{bands: 8,   lib: 4, thr: 2,  err: 1'b0};
        vecs[6] = '{bands: 255, lib: 1, thr: 64, err: 1'b0};

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        hsp_bands = '0; hsp_library_size = '0;
        fifo_captured_complete = 1'b0; fifo_captured_empty = 1'b0;
        fifo_ref_empty = 1'b0; fifo_ref_full = 1'b0;
        mse_valid = 1'b0; mse_comparison_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cancelled", 32'(cancelled), 32'd0);
        chk("rst_init", 32'(initialize), 32'd0);
        chk("rst_read_en", 32'(fifo_both_read_en), 32'd0);
        chk("rst_valid", 32'(band_pack_valid), 32'd0);
        chk("rst_pix", 32'(pixel_count), 32'd0);
        chk("rst_ref", 32'(hsp_ref_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            do_pixel(vecs[i].bands, vecs[i].lib, vecs[i].thr, vecs[i].err,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            b = $urandom_range(1, 40);
            l = $urandom_range(1, 6);
            do_pixel(b, l, (b + BPP - 1) / BPP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Continuous: configuration must be retained even if the inputs change.
        do_pixel(10, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hsp_bands = 8'd4; hsp_library_size = 8'd5;
        do_pixel(10, 2, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_pixel(10, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("cont_pix_total", 32'(pixel_count), 32'd3);

        // clear in DONE overrides the continuous re-arm
        do_pixel(6, 2, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int s = 0; s < 5; s++) clear_in(s);

        go_compute(4, 2);
        run_to_wait();
        n = 0;
        while (n < 200) begin
            step();
            n++;
            #1;
            if (error) break;
        end
        chk("wd_cycles", 32'(n), 32'(TMO));
        chk("wd_init", 32'(initialize), 32'd1);
        step(); #1;
        chk("wd_to_idle", 32'(idle), 32'd1);

        go_compute(8, 3);
        step();
        fifo_ref_full = 1'b1; step(); fifo_ref_full = 1'b0; #1;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_init", 32'(initialize), 32'd1);
        step(); #1;
        chk("ovf_idle", 32'(idle), 32'd1);
        chk("ovf_ref_zero", 32'(hsp_ref_count), 32'd0);

        do_pixel(10, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        go_compute(10, 3);
        step(); #1;
        chk("prerst_valid", 32'(band_pack_valid), 32'd1);
        rst_n = 1'b0; #1;
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_valid", 32'(band_pack_valid), 32'd0);
        chk("midrst_pix", 32'(pixel_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        do_pixel(7, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
